// File: rtl/mxrv_if_id_pkg.sv
// Shared word width, reset level and instruction constants for the mxrv fetch/decode boundary.
`ifndef MXRV_DEFINES
`define MXRV_DEFINES
`define PORT_WORD_WIDTH 32
`define RstEnable 1'b1
`define Enable 1'b1
`define Disable 1'b0
`define ZeroWord 32'h0000_0000
`define INST_NOP 32'h0000_0013
`endif

package mxrv_if_id_pkg;
    localparam int WORD_W = `PORT_WORD_WIDTH;
    localparam logic RST_EN = `RstEnable;
    localparam logic [31:0] NOP_WORD = `INST_NOP;
    localparam logic [31:0] ZERO_WORD = `ZeroWord;
endpackage

// File: rtl/mxrv_sync_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; full/empty are decided from the occupancy count.
module mxrv_sync_fifo
    import mxrv_if_id_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard here too so a misbehaving parent cannot overflow or underflow the count.
    assign do_push = push && !flush && (count != DEPTH_C);
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_EN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mxrv_if_id.sv
// Fetch-to-decode buffer: packs {pc, inst} into a small FIFO, gates delivery with hold, shows NOP when empty.
module mxrv_if_id
    import mxrv_if_id_pkg::*;
#(
    parameter int DW                = WORD_W,
    parameter int DEPTH             = 2,
    parameter logic [DW-1:0] NOP_INST = DW'(NOP_WORD),
    localparam int CW               = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_inst_valid_i,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] inst_i,
    output logic          if_ready_o,
    input  logic          flush_i,
    input  logic          hold_i,
    output logic          id_valid_o,
    output logic [DW-1:0] id_pc_o,
    output logic [DW-1:0] id_inst_o,
    input  logic          id_ready_i,
    output logic [CW-1:0] count_o
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge only when valid and ready are both high
    // in that cycle and flush_i is low; valid never depends on ready in the same cycle.
    logic [2*DW-1:0] head;
    logic            push;
    logic            pop;
    logic            not_empty;

    assign not_empty  = (count_o != '0);
    // Registered back-pressure: depends on count only, so a same-cycle pop never frees a slot.
    assign if_ready_o = (count_o < DEPTH_C);
    assign id_valid_o = not_empty && !hold_i;
    assign push       = pc_inst_valid_i && if_ready_o && !flush_i;
    assign pop        = id_valid_o && id_ready_i && !flush_i;

    always_comb begin
        id_pc_o   = DW'(ZERO_WORD);
        id_inst_o = NOP_INST;
        if (not_empty) begin
            id_pc_o   = head[2*DW-1:DW];
            id_inst_o = head[DW-1:0];
        end
    end

    mxrv_sync_fifo #(
        .W     (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .wdata ({pc_i, inst_i}),
        .rdata (head),
        .count (count_o)
    );
endmodule

// File: doc/mxrv_if_id.md
Name: mxrv_if_id

Overview:
Fetch-to-decode pipeline buffer.
- Sits directly downstream of mxrv_if. Captures each {pc, instruction} pair it emits and presents the pairs in order to the decode stage over a valid/ready handshake.
- Absorbs decode back-pressure with a small FIFO and returns registered back-pressure to fetch.
- Discards all buffered and in-flight instructions on a control-flow flush (jump/branch taken) from execute.

Parameters:
DW, 32, data/address width; matches `PORT_WORD_WIDTH.
DEPTH, 2, number of buffer entries; power of two, >= 2.
NOP_INST, 32'h0000_0013, instruction driven to decode when the buffer is empty (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
pc_inst_valid_i  input  1  fetch presents a valid pair this cycle.
pc_i  input  DW  pc of the presented instruction.
inst_i  input  DW  instruction word.
if_ready_o  output  1  buffer can accept a pair this cycle.
flush_i  input  1  discard everything: buffered entries and this cycle's input.
hold_i  input  1  pipeline hold from control; freezes output to decode.
id_valid_o  output  1  head entry valid toward decode.
id_pc_o  output  DW  pc of head entry.
id_inst_o  output  DW  instruction of head entry.
id_ready_i  input  1  decode accepts the head entry this cycle.
count_o  output  $clog2(DEPTH)+1  current occupancy, for debug/perf.

Behaviour:
- Reset (asynchronous, rst=1):
  - Read/write pointers and count go to 0.
  - if_ready_o=1, id_valid_o=0, id_pc_o=0, id_inst_o=NOP_INST, count_o=0.
  - Storage contents need no reset.
- Push: pc_inst_valid_i && if_ready_o && !flush_i.
  - Writes {pc_i, inst_i} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Pop: id_valid_o && id_ready_i && !flush_i.
  - rd_ptr increments and wraps modulo DEPTH.
- if_ready_o = (count < DEPTH).
  - Depends only on registered count; no combinational path from id_ready_i or pc_inst_valid_i.
  - When full, a push is refused even if a pop occurs in the same cycle.
- id_valid_o = (count != 0) && !hold_i.
  - id_pc_o/id_inst_o are read from the head entry when count != 0.
  - When count == 0: id_pc_o=0, id_inst_o=NOP_INST.
  - While hold_i=1, the head entry stays unchanged and no pop occurs. id_pc_o/id_inst_o still show the head.
- Latency: a pair pushed in cycle N is visible on id_* in cycle N+1 at the earliest. There is no bypass.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged; legal only when 0 < count < DEPTH.
  - Count never exceeds DEPTH and never underflows.
- Flush (flush_i=1), next edge:
  - count, rd_ptr and wr_ptr all go to 0.
  - The concurrent input pair is dropped and the concurrent pop is suppressed.
  - In the cycle after a flush: id_valid_o=0 and if_ready_o=1.
- Priority: rst > flush_i > hold_i > normal push/pop.
  - flush_i together with hold_i flushes.
- Ordering: strict FIFO; pairs are never reordered or duplicated.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty is decided from count.
- Reset mid-operation: all entries are lost immediately and the reset values apply asynchronously.

Decomposition:
- Shared defines header:
  - `PORT_WORD_WIDTH, `RstEnable (=1'b1 for this block), `Enable/`Disable, `ZeroWord.
  - `INST_NOP (32'h0000_0013), used as the NOP_INST default.
- One natural sub-module: mxrv_sync_fifo.
  - Generic parameterised DEPTH x (2*DW) storage with push/pop/flush/count.
  - mxrv_if_id wraps it with the hold gating, the NOP substitution and the pc/inst packing.

Test Plan:
1. Reset release, no input -> if_ready_o=1, id_valid_o=0, id_inst_o=32'h00000013, count_o=0.
2. Push pc=0x0,0x4 with id_ready_i=0 -> count_o=2, if_ready_o=0. Push pc=0x8 -> refused. Raise id_ready_i -> decode receives 0x0 then 0x4 in order; 0x8 is not present.
3. Streaming, pc_inst_valid_i=1 every cycle with id_ready_i=1, pcs 0x0,0x4,0x8... -> each pair appears on id_* one cycle after push. Count stays 1. Throughput is 1/cycle.
4. Buffer holding 0x10,0x14; flush_i=1 in the same cycle as push of 0x18 and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0, id_inst_o=NOP. Neither 0x10 nor 0x18 is ever accepted by decode.
5. hold_i=1 for 3 cycles with count=1 (pc=0x20), id_ready_i=1 -> id_valid_o=0, id_pc_o stays 0x20, count unchanged. After hold drops, 0x20 is popped exactly once.
6. Assert rst asynchronously mid-cycle with count=2 -> outputs take reset values before the next clock edge. After release, the first push (pc=0x100) is the next pair delivered.
